// File: rtl/rom_sequencer.sv
// rom_sequencer: walks an instruction ROM address range, with pause bubbles, early stop on the ALU zero flag and a fixed drain.
module rom_sequencer #(
  parameter int ADDR_W = 7,
  parameter int LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic              pause,
  input  logic              halt_on_zero,
  input  logic              zero_flag,
  output logic [ADDR_W-1:0] dir,
  output logic              en,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              halted,
  output logic [ADDR_W:0]   count
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  localparam int DW = LAT > 1 ? $clog2(LAT) : 1;
  state_t state, nxt;
  logic [ADDR_W-1:0] pc, pc_d, end_q, end_d, dir_d;
  logic [ADDR_W:0] count_d;
  logic [DW-1:0] dc, dc_d;
  logic en_d, done_d, err_d, halted_d, last, last_d, s1v, hz;
  assign hz = halt_on_zero & zero_flag & s1v;
  always_comb begin
    nxt = state;
    pc_d = pc;
    end_d = end_q;
    dir_d = dir;
    count_d = count;
    dc_d = dc;
    en_d = 1'b0;
    done_d = 1'b0;
    err_d = 1'b0;
    halted_d = halted;
    last_d = last;
    case (state)
      IDLE: if (start) begin
        if (start_addr <= end_addr) begin
          nxt = ISSUE;
          pc_d = start_addr;
          end_d = end_addr;
          count_d = '0;
          halted_d = 1'b0;
          last_d = 1'b0;
        end else begin
          err_d = 1'b1;
          done_d = 1'b1;
        end
      end
      // last marks the cycle end_addr is on the bus; a zero-halt seen then still counts
      ISSUE: if (last || hz) begin
        nxt = DRAIN;
        dc_d = '0;
        halted_d = halted | hz;
      end else if (!pause) begin
        en_d = 1'b1;
        dir_d = pc;
        count_d = count + 1'b1;
        last_d = pc == end_q;
        pc_d = pc == end_q ? pc : pc + 1'b1;
      end
      DRAIN: if (dc == DW'(LAT - 1)) begin
        nxt = DONE;
        done_d = 1'b1;
      end else dc_d = dc + 1'b1;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      pc <= '0;
      end_q <= '0;
      dir <= '0;
      count <= '0;
      dc <= '0;
      en <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      halted <= 1'b0;
      last <= 1'b0;
      s1v <= 1'b0;
    end else begin
      state <= nxt;
      pc <= pc_d;
      end_q <= end_d;
      dir <= dir_d;
      count <= count_d;
      dc <= dc_d;
      en <= en_d;
      busy <= nxt == ISSUE || nxt == DRAIN;
      done <= done_d;
      err <= err_d;
      halted <= halted_d;
      last <= last_d;
      s1v <= en;
    end
endmodule
